// File: rtl/terminal_tx_queue.sv
// Memory-mapped transmit FIFO between the CPU bus and the terminal sink.
// A paced drain engine emits one byte per DRAIN_INTERVAL cycles on term_write/term_data.
module terminal_tx_queue #(
  parameter int DEPTH          = 16,
  parameter int DRAIN_INTERVAL = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [1:0]  bus_address,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        term_write,
  output logic [7:0]  term_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(DRAIN_INTERVAL + 1);

  typedef enum logic {IDLE, GAP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          enable;
  logic [31:0]   dropped;
  state_t        state;
  logic [GW-1:0] gap_cnt;

  logic full, empty, push_req, push, pop, ctrl_wr, flush, drop_clr;
  logic [31:0] status;
  logic unused_wdata;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_req = bus_write && (bus_address == 2'd0);
  assign push     = push_req && !full;
  assign pop      = (state == IDLE) && enable && !empty;
  assign ctrl_wr  = bus_write && (bus_address == 2'd2);
  assign flush    = ctrl_wr && bus_write_data[1];
  assign drop_clr = bus_write && (bus_address == 2'd3);
  assign status   = {16'b0, 8'(count), 4'b0, state == GAP, enable, full, empty};
  assign unused_wdata = ^bus_write_data[31:8];

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= bus_write_data[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      enable        <= 1'b1;
      dropped       <= '0;
      state         <= IDLE;
      gap_cnt       <= '0;
      term_write    <= 1'b0;
      term_data     <= '0;
      bus_read_data <= '0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Flush clears the pointers but leaves any emitted pulse and GAP alone.
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end

      if (ctrl_wr) enable <= bus_write_data[0];

      // A clear on the same edge as an overflow takes priority.
      if (drop_clr)                             dropped <= '0;
      else if (push_req && full && ~&dropped) dropped <= dropped + 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            term_write <= 1'b1;
            term_data  <= mem[head];
            if (DRAIN_INTERVAL > 1) begin
              gap_cnt <= GW'(DRAIN_INTERVAL - 1);
              state   <= GAP;
            end
          end else begin
            term_write <= 1'b0;
          end
        end
        GAP: begin
          term_write <= 1'b0;
          gap_cnt    <= gap_cnt - 1'b1;
          if (gap_cnt == GW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (bus_read) begin
        case (bus_address)
          2'd0:    bus_read_data <= '0;
          2'd1:    bus_read_data <= status;
          2'd2:    bus_read_data <= {31'b0, enable};
          default: bus_read_data <= dropped;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_terminal_tx_queue.sv
// Bench for terminal_tx_queue: two instances (interval 4 and 1) share one bus and are
// checked every cycle against a queue-based model, plus directed vectors and sequences.
module tb_terminal_tx_queue;
  logic        clock = 1'b0, reset = 1'b1;
  logic        bus_write = 1'b0, bus_read = 1'b0;
  logic [1:0]  bus_address = '0;
  logic [31:0] bus_write_data = '0;
  logic [31:0] rd0, rd1;
  logic        tw0, tw1;
  logic [7:0]  td0, td1;

  int errors = 0, checks = 0, pulses0 = 0;

  terminal_tx_queue #(.DEPTH(16), .DRAIN_INTERVAL(4)) u0 (
    .clock(clock), .reset(reset), .bus_write(bus_write), .bus_read(bus_read),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_read_data(rd0), .term_write(tw0), .term_data(td0));

  terminal_tx_queue #(.DEPTH(16), .DRAIN_INTERVAL(1)) u1 (
    .clock(clock), .reset(reset), .bus_write(bus_write), .bus_read(bus_read),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_read_data(rd1), .term_write(tw1), .term_data(td1));

  always #5 clock = ~clock;

  // Reference model: a byte queue per instance; pacing derived from the edge of the last pop.
  logic [7:0]  mq [2][$];
  logic        men [2];
  logic [31:0] mdrop [2];
  int          mlast [2];
  logic        mtw [2];
  logic [7:0]  mtd [2];
  logic [31:0] mrd [2];
  int          ecnt = 0;
  int          di [2] = '{4, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      men[i] = 1'b1; mdrop[i] = '0; mlast[i] = -1000;
      mtw[i] = 1'b0; mtd[i] = '0; mrd[i] = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int   n   = mq[i].size();
      logic fl  = (n == 16);
      logic gap = (ecnt - mlast[i]) < di[i];
      if (bus_read)
        case (bus_address)
          2'd0: mrd[i] = 0;
          2'd1: mrd[i] = (n << 8) | (32'(gap) << 3) | (32'(men[i]) << 2) | (32'(fl) << 1) | 32'(n == 0);
          2'd2: mrd[i] = 32'(men[i]);
          2'd3: mrd[i] = mdrop[i];
        endcase
      if (men[i] && n != 0 && !gap) begin
        mtw[i] = 1'b1; mtd[i] = mq[i].pop_front(); mlast[i] = ecnt;
      end else mtw[i] = 1'b0;
      if (bus_write)
        case (bus_address)
          2'd0: if (fl) begin if (mdrop[i] != 32'hFFFF_FFFF) mdrop[i]++; end
                else mq[i].push_back(bus_write_data[7:0]);
          2'd2: begin men[i] = bus_write_data[0]; if (bus_write_data[1]) mq[i].delete(); end
          2'd3: mdrop[i] = '0;
          default: ;
        endcase
    end
    ecnt++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    chk("tw0", 32'(tw0), 32'(mtw[0])); chk("td0", 32'(td0), 32'(mtd[0])); chk("rd0", rd0, mrd[0]);
    chk("tw1", 32'(tw1), 32'(mtw[1])); chk("td1", 32'(td1), 32'(mtd[1])); chk("rd1", rd1, mrd[1]);
    if (tw0) pulses0++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_write = 1'b1; bus_address = a; bus_write_data = d;
    tick();
    bus_write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus_read = 1'b1; bus_address = a;
    tick();
    bus_read = 1'b0;
    chk(name, rd0, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];

  initial begin
    // Register semantics vectors, applied with DROPPED=2 and a full, disabled queue.
    tbl[0] = '{1'b0, 1'b1, 2'd3, 32'h0,         1'b1, 32'h2};
    tbl[1] = '{1'b1, 1'b0, 2'd3, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 2'd3, 32'h0,         1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h1002};
    tbl[6] = '{1'b1, 1'b1, 2'd2, 32'h3_0001,    1'b1, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h1006};
    tbl[8] = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h0F0C};

    model_reset();
    #3 reset = 1'b0;
    #1;
    chk("reset_tw", 32'(tw0), 0); chk("reset_td", 32'(td0), 0); chk("reset_rd", rd0, 0);
    chk("reset_tw1", 32'(tw1), 0);
    #19 reset = 1'b1;
    idle(2);

    // Basic drain
    wr(2'd0, 32'h48);
    wr(2'd0, 32'h69);
    chk("basic_first_tw", 32'(tw0), 1); chk("basic_first_td", 32'(td0), 32'h48);
    idle(4);
    chk("basic_second_tw", 32'(tw0), 1); chk("basic_second_td", 32'(td0), 32'h69);
    idle(4);
    rd("basic_status", 2'd1, 32'h5);

    // Overflow
    wr(2'd2, 32'h0);
    for (int b = 0; b <= 16; b++) wr(2'd0, 32'(b));
    rd("ovf_status", 2'd1, 32'h1002);
    rd("ovf_dropped", 2'd3, 32'h1);
    wr(2'd2, 32'h1);
    pulses0 = 0;
    idle(70);
    chk("ovf_pulses", 32'(pulses0), 16);
    rd("ovf_empty", 2'd1, 32'h5);

    // Register semantics table
    wr(2'd2, 32'h0);
    for (int b = 0; b < 17; b++) wr(2'd0, 32'(8'h30 + b));
    for (int v = 0; v < 9; v++) begin
      bus_write = tbl[v].wr; bus_read = tbl[v].rd;
      bus_address = tbl[v].addr; bus_write_data = tbl[v].wdata;
      tick();
      bus_write = 1'b0; bus_read = 1'b0;
      if (tbl[v].chk) chk($sformatf("vec%0d", v), rd0, tbl[v].exp);
    end

    // Flush with enable low
    wr(2'd2, 32'h0);
    idle(5);
    wr(2'd2, 32'h2);
    rd("flush_status", 2'd1, 32'h1);
    wr(2'd2, 32'h1);
    pulses0 = 0;
    idle(12);
    chk("flush_no_pulse", 32'(pulses0), 0);

    // Back-to-back drain on the interval-1 instance
    wr(2'd2, 32'h0);
    wr(2'd0, 32'hA1); wr(2'd0, 32'hA2); wr(2'd0, 32'hA3);
    wr(2'd2, 32'h1);
    tick(); chk("b2b_tw_a", 32'(tw1), 1); chk("b2b_td_a", 32'(td1), 32'hA1);
    tick(); chk("b2b_tw_b", 32'(tw1), 1); chk("b2b_td_b", 32'(td1), 32'hA2);
    tick(); chk("b2b_tw_c", 32'(tw1), 1); chk("b2b_td_c", 32'(td1), 32'hA3);
    tick(); chk("b2b_tw_end", 32'(tw1), 0);
    idle(10);

    // Overflow followed by clear
    wr(2'd2, 32'h0);
    for (int b = 0; b < 17; b++) wr(2'd0, 32'(8'h70 + b));
    wr(2'd3, 32'h0);
    rd("clr_dropped", 2'd3, 32'h0);
    wr(2'd0, 32'hEE);
    wr(2'd2, 32'h2);

    // Asynchronous reset while a byte is on term_write
    for (int b = 0; b < 4; b++) wr(2'd0, 32'(8'h51 + b));
    wr(2'd2, 32'h1);
    tick();
    chk("pre_reset_tw", 32'(tw0), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_tw0", 32'(tw0), 0); chk("async_td0", 32'(td0), 0);
    chk("async_tw1", 32'(tw1), 0); chk("async_td1", 32'(td1), 0);
    model_reset();
    @(negedge clock);
    @(negedge clock) reset = 1'b1;
    rd("post_reset_status", 2'd1, 32'h5);
    rd("post_reset_dropped", 2'd3, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      int unsigned r = $urandom_range(0, 9);
      bus_read    = $urandom_range(0, 1);
      bus_write   = (r != 9);
      bus_address = (r <= 5) ? 2'd0 : (r == 6) ? 2'd2 : (r == 7) ? 2'd3 : 2'd1;
      bus_write_data = $urandom;
      if (r == 6) bus_write_data[1:0] = {($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
      if (bus_read) bus_address = (bus_write && $urandom_range(0, 1)) ? bus_address : 2'($urandom);
      tick();
    end
    bus_write = 1'b0; bus_read = 1'b0;
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
